// File: rtl/tone_pkg.sv
// rtl/tone_pkg.sv - shared pitch table, note mapping and FSM encoding for the tone engine
package tone_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } tone_state_t;

    function automatic int ms_cycles(input int clk_hz);
        return (clk_hz < 1000) ? 1 : clk_hz / 1000;
    endfunction

    // Half-period cycle counts of the C3 octave; index is the semitone 1..12 (C..B), 0 = rest.
    function automatic logic [31:0] base_c3_hp(input logic [3:0] semi);
        case (semi)
            4'd1:    return 32'd381680;
            4'd2:    return 32'd360260;
            4'd3:    return 32'd340136;
            4'd4:    return 32'd321034;
            4'd5:    return 32'd303030;
            4'd6:    return 32'd285714;
            4'd7:    return 32'd269687;
            4'd8:    return 32'd255102;
            4'd9:    return 32'd240790;
            4'd10:   return 32'd227273;
            4'd11:   return 32'd214518;
            4'd12:   return 32'd202429;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [3:0] note_to_semi(input logic [3:0] note, input logic chromatic);
        logic [3:0] semi;
        semi = 4'd0;
        if (chromatic) begin
            if (note >= 4'd1 && note <= 4'd12) semi = note;
        end else begin
            case (note)
                4'd1:    semi = 4'd1;
                4'd2:    semi = 4'd3;
                4'd3:    semi = 4'd5;
                4'd4:    semi = 4'd6;
                4'd5:    semi = 4'd8;
                4'd6:    semi = 4'd10;
                4'd7:    semi = 4'd12;
                default: semi = 4'd0;
            endcase
        end
        return semi;
    endfunction

endpackage

// File: rtl/tone_sequencer_if.sv
// rtl/tone_sequencer_if.sv - note request handshake between the song logic and the tone engine
interface tone_sequencer_if #(
    parameter int DUR_W = 16,
    parameter int VOL_W = 3
) ();
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_note;
    logic [2:0]       req_octave;
    logic [DUR_W-1:0] req_dur_ms;
    logic [VOL_W-1:0] req_volume;

    modport master (
        output req_valid, req_note, req_octave, req_dur_ms, req_volume,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_note, req_octave, req_dur_ms, req_volume,
        output req_ready
    );
endinterface

// File: rtl/tone_osc.sv
// rtl/tone_osc.sv - half-period counter that toggles a square-wave phase every i_hp cycles
module tone_osc #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] i_hp,
    input  logic             i_en,
    output logic             o_phase
);
    logic [CNT_W-1:0] r_cnt;
    logic             r_phase;

    // Dropping i_en restarts the wave at phase 0 so every note begins identically.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (!i_en) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (r_cnt == i_hp - 1'b1) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_phase = r_phase;
endmodule

// File: rtl/tone_sequencer.sv
// rtl/tone_sequencer.sv - timed square-wave note player with octave shift, PWM volume and abort
module tone_sequencer
    import tone_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int CNT_W     = 32,
    parameter int CHROMATIC = 1,
    parameter int OCT_MIN   = -2,
    parameter int OCT_MAX   = 2,
    parameter int VOL_W     = 3,
    parameter int DUR_W     = 16,
    parameter int GAP_MS    = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    tone_sequencer_if.slave req,
    input  logic         abort,
    output logic         speaker,
    output logic         busy,
    output logic         done
);
    localparam int               MS_CYC  = ms_cycles(CLK_HZ);
    localparam logic [CNT_W-1:0] MS_LAST = CNT_W'(MS_CYC - 1);
    localparam logic [DUR_W-1:0] GAP_LEN = DUR_W'(GAP_MS);

    tone_state_t      r_state, w_state_nx;
    logic [CNT_W-1:0] r_ms_cnt;
    logic [DUR_W-1:0] r_ms_left;
    logic [CNT_W-1:0] r_hp;
    logic [VOL_W-1:0] r_vol;
    logic [VOL_W-1:0] r_pc;
    logic             r_audible;
    logic             r_zero_done;

    logic             w_accept;
    logic             w_ms_tick;
    logic             w_last_ms;
    logic             w_done;
    logic             w_phase;
    logic             w_pwm;
    logic [3:0]       w_semi;
    logic [31:0]      w_base;
    logic [CNT_W+7:0] w_wide;
    logic [CNT_W-1:0] w_hp;
    logic             w_audible;
    int               w_oct;

    // abort wins over a coincident handshake: the request is simply not taken.
    assign w_accept  = req.req_valid & (r_state == ST_IDLE) & ~abort;
    assign w_ms_tick = (r_ms_cnt == MS_LAST);
    assign w_last_ms = w_ms_tick && (r_ms_left == DUR_W'(1));

    always_comb begin
        w_semi    = note_to_semi(req.req_note, CHROMATIC != 0);
        w_base    = base_c3_hp(w_semi);
        w_audible = (w_semi != 4'd0);
        w_oct     = int'($signed(req.req_octave));
        if (w_oct < OCT_MIN) w_oct = OCT_MIN;
        if (w_oct > OCT_MAX) w_oct = OCT_MAX;
        w_wide = (CNT_W+8)'(w_base);
        if (w_oct < 0) w_wide = w_wide << (-w_oct);
        else           w_wide = w_wide >> w_oct;
        if (|w_wide[CNT_W+7:CNT_W]) w_hp = '1;
        else                        w_hp = w_wide[CNT_W-1:0];
        if (w_hp == '0) w_hp = CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_done     = 1'b0;
        if (abort) begin
            w_state_nx = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept && req.req_dur_ms != '0) w_state_nx = ST_PLAY;
                ST_PLAY: if (w_last_ms) begin
                    if (GAP_MS == 0) begin
                        w_state_nx = ST_IDLE;
                        w_done     = 1'b1;
                    end else begin
                        w_state_nx = ST_GAP;
                    end
                end
                ST_GAP: if (w_last_ms) begin
                    w_state_nx = ST_IDLE;
                    w_done     = 1'b1;
                end
                default: w_state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ms_cnt    <= '0;
            r_ms_left   <= '0;
            r_hp        <= '0;
            r_vol       <= '0;
            r_pc        <= '0;
            r_audible   <= 1'b0;
            r_zero_done <= 1'b0;
        end else begin
            r_pc        <= r_pc + 1'b1;
            r_zero_done <= w_accept && (req.req_dur_ms == '0);
            if (w_accept) begin
                r_hp      <= w_hp;
                r_vol     <= req.req_volume;
                r_audible <= w_audible;
                r_ms_cnt  <= '0;
                r_ms_left <= req.req_dur_ms;
            end else if (r_state != ST_IDLE) begin
                r_ms_cnt <= w_ms_tick ? '0 : r_ms_cnt + 1'b1;
                // The ms countdown is reused for the gap once the tone has run out.
                if (w_ms_tick)
                    r_ms_left <= (w_last_ms && r_state == ST_PLAY) ? GAP_LEN : r_ms_left - 1'b1;
            end
        end
    end

    tone_osc #(.CNT_W(CNT_W)) u_osc (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_hp   (r_hp),
        .i_en   (r_state == ST_PLAY),
        .o_phase(w_phase)
    );

    assign w_pwm         = (r_vol == '1) | (r_pc < r_vol);
    assign speaker       = (r_state == ST_PLAY) & r_audible & w_phase & w_pwm;
    assign busy          = (r_state != ST_IDLE);
    assign req.req_ready = (r_state == ST_IDLE);
    assign done          = w_done | r_zero_done;
endmodule

// File: tb/tb_tone_sequencer.sv
// tb/tb_tone_sequencer.sv - scoreboard bench for tone_sequencer with random notes and a reference model
module tb_tone_sequencer;

    typedef struct {
        int     lat;
        int     play_len;
        longint hp;
        bit     audible;
        int     vol;
        int     abort_at;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic abort0 = 1'b0, abort1 = 1'b0;
    logic spk0, busy0, done0, spk1, busy1, done1;

    tone_sequencer_if #(.DUR_W(16), .VOL_W(3)) if0 ();
    tone_sequencer_if #(.DUR_W(16), .VOL_W(3)) if1 ();

    tone_sequencer #(.CLK_HZ(8000), .CNT_W(32), .CHROMATIC(1), .OCT_MIN(-2), .OCT_MAX(2),
                     .VOL_W(3), .DUR_W(16), .GAP_MS(5)) u0 (
        .clk(clk), .rst_n(rst_n), .req(if0), .abort(abort0),
        .speaker(spk0), .busy(busy0), .done(done0));

    tone_sequencer #(.CLK_HZ(4000), .CNT_W(20), .CHROMATIC(0), .OCT_MIN(-2), .OCT_MAX(2),
                     .VOL_W(3), .DUR_W(16), .GAP_MS(0)) u1 (
        .clk(clk), .rst_n(rst_n), .req(if1), .abort(abort1),
        .speaker(spk1), .busy(busy1), .done(done1));

    always #5 clk = ~clk;

    int     errors = 0;
    int     checks = 0;
    int     idle_bad = 0;
    bit     sel = 1'b0;
    bit     mon_active = 1'b0;
    longint tb_pc;
    exp_t   exp_q[$];

    logic   m_valid, m_ready, m_abort, m_spk, m_busy, m_done;
    longint m_hp;
    assign m_valid = sel ? if1.req_valid : if0.req_valid;
    assign m_ready = sel ? if1.req_ready : if0.req_ready;
    assign m_abort = sel ? abort1 : abort0;
    assign m_spk   = sel ? spk1 : spk0;
    assign m_busy  = sel ? busy1 : busy0;
    assign m_done  = sel ? done1 : done0;
    assign m_hp    = sel ? longint'(u1.r_hp) : longint'(u0.r_hp);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_pc <= 0;
        else        tb_pc <= tb_pc + 1;
    end

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0d, required %0d", name, act, req);
        end
    endtask

    function automatic exp_t model(input int note, input int oct, input int dur, input int vol,
                                   input int abort_at);
        longint base [12] = '{381680, 360260, 340136, 321034, 303030, 285714,
                              269687, 255102, 240790, 227273, 214518, 202429};
        int     dmap [7]  = '{1, 3, 5, 6, 8, 10, 12};
        exp_t   e;
        int     semi, o, m, gap;
        longint sat, hp;
        m    = sel ? 4 : 8;
        gap  = sel ? 0 : 5;
        sat  = sel ? 64'd1048575 : 64'd4294967295;
        semi = 0;
        if (!sel && note >= 1 && note <= 12) semi = note;
        if (sel && note >= 1 && note <= 7)   semi = dmap[note-1];
        o = (oct < -2) ? -2 : (oct > 2) ? 2 : oct;
        hp = (semi != 0) ? base[semi-1] : 0;
        if (o < 0) hp = hp * (64'd1 << (-o));
        else       hp = hp / (64'd1 << o);
        if (hp > sat) hp = sat;
        e.hp       = hp;
        e.audible  = (semi != 0);
        e.vol      = vol;
        e.play_len = dur * m;
        e.lat      = (dur == 0) ? 1 : (dur + gap) * m;
        e.abort_at = abort_at;
        return e;
    endfunction

    task automatic put(input int note, input int oct, input int dur, input int vol);
        if (!sel) begin
            if0.req_note = 4'(note); if0.req_octave = 3'(oct);
            if0.req_dur_ms = 16'(dur); if0.req_volume = 3'(vol); if0.req_valid = 1'b1;
        end else begin
            if1.req_note = 4'(note); if1.req_octave = 3'(oct);
            if1.req_dur_ms = 16'(dur); if1.req_volume = 3'(vol); if1.req_valid = 1'b1;
        end
    endtask

    task automatic set_ctl(input logic valid, input logic ab);
        if (!sel) begin if0.req_valid = valid; abort0 = ab; end
        else      begin if1.req_valid = valid; abort1 = ab; end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(posedge clk); #1;
        while ((!m_ready || mon_active) && n < 60000) begin
            @(posedge clk); #1;
            n++;
        end
        check("driver_wait_idle", longint'(n < 60000), 1);
    endtask

    task automatic send(input int note, input int oct, input int dur, input int vol, input int abort_at);
        wait_idle();
        exp_q.push_back(model(note, oct, dur, vol, abort_at));
        put(note, oct, dur, vol);
        @(posedge clk); #1;
        set_ctl(1'b0, 1'b0);
        if (abort_at > 0) begin
            repeat (abort_at - 1) @(posedge clk);
            #1 set_ctl(1'b0, 1'b1);
            @(posedge clk); #1 set_ctl(1'b0, 1'b0);
        end
    endtask

    task automatic send_random(input int n);
        for (int i = 0; i < n; i++) begin
            int   note, oct, dur, vol, ab;
            exp_t t;
            note = int'($urandom_range(0, 15));
            oct  = int'($urandom_range(0, 7)) - 4;
            dur  = int'($urandom_range(0, 12));
            vol  = int'($urandom_range(0, 7));
            t    = model(note, oct, dur, vol, 0);
            ab   = (dur > 0 && $urandom_range(0, 5) == 0) ? int'($urandom_range(1, t.lat)) : 0;
            send(note, oct, dur, vol, ab);
        end
    endtask

    task automatic driver();
        send(10, 0, 10, 7, 0);
        send(10, 1, 3, 7, 0);
        send(10, 3, 3, 7, 0);
        send(1, -3, 4, 2, 0);
        send(7, 0, 0, 5, 0);
        send(5, 0, 10, 7, 20);
        send(5, 0, 10, 7, 85);
        wait_idle();
        put(3, 0, 4, 7);
        set_ctl(1'b1, 1'b1);
        @(posedge clk); #1 set_ctl(1'b0, 1'b0);
        send(2, 0, 2, 7, 0);
        send_random(25);
        send(12, 2, 6330, 2, 0);
        wait_idle();
        sel = 1'b1;
        send(5, 0, 3, 7, 0);
        send(13, 0, 2, 7, 0);
        send(0, 0, 2, 7, 0);
        send(8, 0, 1, 7, 0);
        send(1, -2, 2, 7, 0);
        send(1, -1, 2, 7, 0);
        send(3, 1, 0, 7, 0);
        send(6, 0, 4, 7, 7);
        send_random(10);
        wait_idle();
        repeat (10) @(posedge clk);
    endtask

    task automatic monitor();
        exp_t cur;
        int   cnt = 0, bad = 0, first_bad = -1;
        bit   post_abort = 1'b0;
        bit   exp_spk;
        forever begin
            @(negedge clk);
            if (post_abort) begin
                check("abort_next_cycle_spk_busy_ready_done", {m_spk, m_busy, m_ready, m_done}, 4'b0010);
                post_abort = 1'b0;
            end
            if (mon_active) begin
                cnt++;
                exp_spk = (cnt <= cur.play_len) && cur.audible && cur.hp > 0 &&
                          (((longint'(cnt - 1) / cur.hp) % 2) == 1) &&
                          (cur.vol == 7 || (tb_pc % 8) < cur.vol);
                if (m_spk !== exp_spk || m_busy !== (cur.play_len > 0)) begin
                    bad++;
                    if (first_bad < 0) first_bad = cnt;
                end
                if (cnt == 1 && cur.audible) check("half_period", m_hp, cur.hp);
                if (cur.abort_at == cnt && m_abort) begin
                    check("no_done_on_abort", m_done, 0);
                    check("speaker_busy_during_note", bad, 0);
                    mon_active = 1'b0;
                    post_abort = 1'b1;
                end else if (m_done) begin
                    check("done_latency", cnt, cur.lat);
                    if (bad != 0) $display("FAIL speaker_busy first bad cycle %0d", first_bad);
                    check("speaker_busy_during_note", bad, 0);
                    mon_active = 1'b0;
                end else if (cnt > cur.lat + 8) begin
                    check("done_seen_within_bound", 0, 1);
                    mon_active = 1'b0;
                end
            end else begin
                if (m_spk !== 1'b0 || m_busy !== 1'b0) idle_bad++;
                if (m_done !== 1'b0 && !post_abort) check("unexpected_done", m_done, 0);
            end
            if (!mon_active && m_valid && m_ready && !m_abort) begin
                if (exp_q.size() == 0) begin
                    check("accept_with_expectation", 0, 1);
                end else begin
                    cur        = exp_q.pop_front();
                    mon_active = 1'b1;
                    cnt        = 0;
                    bad        = 0;
                    first_bad  = -1;
                end
            end else if (!mon_active && m_valid && m_abort) begin
                check("ready_during_abort_handshake", m_ready, 1);
            end
        end
    endtask

    initial begin
        if0.req_valid = 1'b0; if0.req_note = '0; if0.req_octave = '0;
        if0.req_dur_ms = '0; if0.req_volume = '0;
        if1.req_valid = 1'b0; if1.req_note = '0; if1.req_octave = '0;
        if1.req_dur_ms = '0; if1.req_volume = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_speaker", spk0, 0);
        check("reset_busy", busy0, 0);
        check("reset_ready", if0.req_ready, 1);
        check("reset_done", done0, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        fork
            driver();
            monitor();
        join_any
        disable fork;
        check("idle_speaker_busy_quiet", idle_bad, 0);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
